edgetracing_mul_share_arbiter: RTL and testbench

//  Shares one pipelined DSP48 multiplier (10b x 6b unsigned, 15b product) between NUM_REQ

---
 rtl/edgetracing_pkg.sv | 17 +
 rtl/edgetracing_accel_mul_mul_10ns_6ns_15_4_1.sv | 39 +++
 rtl/edgetracing_mul_share_arbiter_rr_arbiter.sv | 47 ++++
 rtl/edgetracing_mul_share_arbiter.sv | 114 +++++++++++
 tb/tb_edgetracing_mul_share_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edgetracing_pkg.sv
// Shared constants and types for the edge-tracing accelerator multiplier datapath.
package edgetracing_pkg;

  localparam int unsigned MUL_A_W  = 10;
  localparam int unsigned MUL_B_W  = 6;
  localparam int unsigned MUL_P_W  = 15;
  localparam int unsigned MUL_PIPE = 3;

  // Wide enough for up to 8 requesters; narrower IDs are zero-extended.
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/edgetracing_accel_mul_mul_10ns_6ns_15_4_1.sv
// Pipelined unsigned multiplier: operand regs, product reg, output reg, all gated by ce.
module edgetracing_accel_mul_mul_10ns_6ns_15_4_1 #(
  parameter int unsigned ID         = 1,
  parameter int unsigned NUM_STAGE  = 4,
  parameter int unsigned din0_WIDTH = 10,
  parameter int unsigned din1_WIDTH = 6,
  parameter int unsigned dout_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic [din0_WIDTH-1:0] a_reg;
  logic [din1_WIDTH-1:0] b_reg;
  logic [dout_WIDTH-1:0] a_ext, b_ext, p_tmp, p_reg;

  // Multiplying at output width keeps only the low bits; overflow wraps.
  assign a_ext = dout_WIDTH'(a_reg);
  assign b_ext = dout_WIDTH'(b_reg);

  always_ff @(posedge clk) begin
    if (ce) begin
      a_reg <= din0;
      b_reg <= din1;
      p_tmp <= a_ext * b_ext;
      p_reg <= p_tmp;
    end
  end

  assign dout = p_reg;

  logic unused_cfg;
  assign unused_cfg = ^{reset, 32'(ID), 32'(NUM_STAGE)};

endmodule

// File: rtl/edgetracing_mul_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer, pointer moves past each accepted winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ID_W'((32'(gnt_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/edgetracing_mul_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters; results return tagged with
// the requester ID, and consumer backpressure freezes the whole pipe via ce.
module edgetracing_mul_share_arbiter
  import edgetracing_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MUL_A_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_B_W-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [MUL_P_W-1:0]         rsp_p,
  output logic                       busy
);

  // Issue register plus one tag stage per multiplier register.
  localparam int unsigned TagStages = MUL_PIPE + 1;

  logic               ce, grant_en, hs;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [MUL_A_W-1:0] op_a, issue_a_q;
  logic [MUL_B_W-1:0] op_b, issue_b_q;
  mul_tag_t           tag_d;
  mul_tag_t           tag_q [TagStages];

  assign ce       = ~rsp_valid | rsp_ready;
  // Holding grants off during reset keeps req_ready low for the reset cycle itself.
  assign grant_en = arb_en & ce & ap_rst_n;
  assign hs       = |(req_valid & gnt);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .req     (req_valid),
    .en      (grant_en),
    .advance (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_a = req_a[MUL_A_W*i +: MUL_A_W];
        op_b = req_b[MUL_B_W*i +: MUL_B_W];
      end
    end
  end

  always_comb begin
    tag_d       = '0;
    tag_d.valid = hs;
    tag_d.id    = TAG_ID_W'(gnt_idx);
  end

  always_ff @(posedge ap_clk) begin
    if (ce) begin
      issue_a_q <= op_a;
      issue_b_q <= op_b;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < TagStages; i++) tag_q[i] <= '0;
    end else if (ce) begin
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i < TagStages; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  edgetracing_accel_mul_mul_10ns_6ns_15_4_1 #(
    .ID         (1),
    .NUM_STAGE  (MUL_LAT),
    .din0_WIDTH (MUL_A_W),
    .din1_WIDTH (MUL_B_W),
    .dout_WIDTH (MUL_P_W)
  ) u_mul (
    .clk   (ap_clk),
    .reset (~ap_rst_n),
    .ce    (ce),
    .din0  (issue_a_q),
    .din1  (issue_b_q),
    .dout  (rsp_p)
  );

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < TagStages; i++) busy = busy | tag_q[i].valid;
  end

  assign rsp_valid = tag_q[TagStages-1].valid;
  assign rsp_id    = tag_q[TagStages-1].id[ID_W-1:0];

  logic unused_tag;
  assign unused_tag = ^tag_q[TagStages-1].id;

endmodule

// File: tb/tb_edgetracing_mul_share_arbiter.sv
// Self-checking bench: in-flight operation list with ages as the reference model.
module tb_edgetracing_mul_share_arbiter;

  localparam int NR = 4;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n, arb_en, rsp_ready;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*10-1:0] req_a;
  logic [NR*6-1:0]  req_b;
  logic             rsp_valid, busy;
  logic [1:0]       rsp_id;
  logic [14:0]      rsp_p;

  always #5 ap_clk = ~ap_clk;

  edgetracing_mul_share_arbiter #(
    .NUM_REQ (NR),
    .ID_W    (2),
    .MUL_LAT (4)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  // Reference model: accepted ops in order, each with the number of pipe advances seen.
  typedef struct {
    int id;
    int p;
    int age;
  } op_t;

  op_t           q[$];
  int            ptr = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [NR-1:0] exp_ready;
  logic          exp_valid, exp_busy, exp_ce;
  int            exp_id, exp_p, exp_w;

  function automatic void model_eval();
    exp_valid = (q.size() > 0) && (q[0].age == 4);
    exp_id    = exp_valid ? q[0].id : 0;
    exp_p     = exp_valid ? q[0].p : 0;
    exp_busy  = q.size() > 0;
    exp_ce    = !exp_valid || rsp_ready;
    exp_w     = -1;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (ptr + k) % NR;
      if (exp_w < 0 && req_valid[c]) exp_w = c;
    end
    exp_ready = '0;
    if (ap_rst_n && arb_en && exp_ce && exp_w >= 0) exp_ready[exp_w] = 1'b1;
  endfunction

  function automatic void model_commit();
    if (!ap_rst_n) begin
      ptr = 0;
      q.delete();
      return;
    end
    if (!exp_ce) return;
    if (exp_valid) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (exp_ready != '0) begin
      op_t o;
      o.id  = exp_w;
      o.p   = (int'(req_a[exp_w*10 +: 10]) * int'(req_b[exp_w*6 +: 6])) % 32768;
      o.age = 1;
      q.push_back(o);
      ptr = (exp_w + 1) % NR;
    end
  endfunction

  task automatic sample();
    @(negedge ap_clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge ap_clk);
    model_commit();
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*10 +: 10] = 10'($urandom_range(0, 1023));
      req_b[i*6 +: 6]   = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    advance();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; arb_en = 1'b1; rsp_ready = 1'b1; req_valid = '1;
    rand_ops();
    advance();
    sample();
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset req_ready: got %b want 0000", req_ready);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid);
    end
    n_checks++;
    if (rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset rsp_id: got %0d want 0", rsp_id);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b want 0", busy);
    end
    advance();
    ap_rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single_op();
    for (int i = 0; i < 8; i++) begin
      req_valid = (i == 0) ? 4'b0001 : 4'b0000;
      req_a = '0; req_b = '0;
      req_a[9:0] = 10'd25; req_b[5:0] = 6'd13;
      sample();
      n_checks++;
      if (rsp_valid !== exp_valid) begin
        n_fail++; $display("FAIL single rsp_valid cyc %0d: got %b want %b", i, rsp_valid, exp_valid);
      end
      if (i == 0) begin
        n_checks++;
        if (req_ready !== 4'b0001) begin
          n_fail++; $display("FAIL single grant: got %b want 0001", req_ready);
        end
      end
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL single busy cyc %0d: got %b want 1", i, busy);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 15'd325) begin
          n_fail++;
          $display("FAIL single result: got v=%b id=%0d p=%0d want v=1 id=0 p=325",
                   rsp_valid, rsp_id, rsp_p);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL single idle busy: got %b want 0", busy);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 5) ? 4'b1111 : 4'b0000;
      rand_ops();
      sample();
      if (i < 5) begin
        n_checks++;
        if (req_ready !== 4'(1 << (i % 4))) begin
          n_fail++;
          $display("FAIL rr grant cyc %0d: got %b want %b", i, req_ready, 4'(1 << (i % 4)));
        end
      end
      if (i >= 4 && i < 9) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((i - 4) % 4) || rsp_p !== 15'(exp_p)) begin
          n_fail++;
          $display("FAIL rr rsp cyc %0d: got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d",
                   i, rsp_valid, rsp_id, rsp_p, (i - 4) % 4, exp_p);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int granted = 0;
    int received = 0;
    for (int i = 0; i < 30; i++) begin
      req_valid = (granted < 6) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rsp_ready = !(i >= 5 && i <= 7);
      rand_ops();
      sample();
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL bp req_ready cyc %0d: got %b want %b", i, req_ready, exp_ready);
      end
      n_checks++;
      if (rsp_valid !== exp_valid) begin
        n_fail++; $display("FAIL bp rsp_valid cyc %0d: got %b want %b", i, rsp_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (rsp_id !== 2'(exp_id) || rsp_p !== 15'(exp_p)) begin
          n_fail++;
          $display("FAIL bp rsp cyc %0d: got id=%0d p=%0d want id=%0d p=%0d",
                   i, rsp_id, rsp_p, exp_id, exp_p);
        end
      end
      if (!rsp_ready && exp_valid) begin
        n_checks++;
        if (req_ready !== 4'b0000) begin
          n_fail++; $display("FAIL bp stall grant cyc %0d: got %b want 0000", i, req_ready);
        end
      end
      if (exp_ready != '0) granted++;
      if (rsp_valid && rsp_ready) received++;
      advance();
    end
    rsp_ready = 1'b1;
    n_checks++;
    if (received !== 6) begin
      n_fail++; $display("FAIL bp count: got %0d responses want 6", received);
    end
  endtask

  task automatic test_width_wrap();
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 2) ? 4'b0100 : 4'b0000;
      req_a[29:20] = (i == 0) ? 10'd1023 : 10'd0;
      req_b[17:12] = 6'd63;
      sample();
      if (i == 4 || i == 5) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
            rsp_p !== ((i == 4) ? 15'd31681 : 15'd0)) begin
          n_fail++;
          $display("FAIL wrap cyc %0d: got v=%b id=%0d p=%0d want v=1 id=2 p=%0d",
                   i, rsp_valid, rsp_id, rsp_p, (i == 4) ? 31681 : 0);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_flight();
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b1111;
      rand_ops();
      sample();
      advance();
    end
    ap_rst_n = 1'b0;
    sample();
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid grant in reset: got %b want 0000", req_ready);
    end
    advance();
    ap_rst_n = 1'b1;
    sample();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid cleared: got v=%b busy=%b id=%0d want 0 0 0", rsp_valid, busy, rsp_id);
    end
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid first grant: got %b want 0001", req_ready);
    end
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      sample();
      n_checks++;
      if (rsp_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rstmid rsp_valid cyc %0d: got %b want %b", i, rsp_valid, exp_valid);
      end
      if (rsp_valid) seen++;
      advance();
    end
    n_checks++;
    if (seen !== 1) begin
      n_fail++; $display("FAIL rstmid result count: got %0d want 1", seen);
    end
  endtask

  task automatic test_arb_en();
    int ptr_saved;
    for (int i = 0; i < 2; i++) begin
      req_valid = 4'b1111; arb_en = 1'b1;
      rand_ops();
      sample();
      advance();
    end
    arb_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL arb_en off grant cyc %0d: got %b want 0000", i, req_ready);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL arb_en drain busy cyc %0d: got %b want %b", i, busy, exp_busy);
      end
      advance();
    end
    sample();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL arb_en drained busy: got %b want 0", busy);
    end
    advance();
    ptr_saved = ptr;
    arb_en = 1'b1;
    sample();
    n_checks++;
    if (req_ready !== 4'(1 << ptr_saved)) begin
      n_fail++; $display("FAIL arb_en resume: got %b want %b", req_ready, 4'(1 << ptr_saved));
    end
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ap_rst_n  = ($urandom_range(0, 49) != 0);
      arb_en    = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = 4'($urandom_range(0, 15));
      rand_ops();
      sample();
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd req_ready cyc %0d: got %b want %b", i, req_ready, exp_ready);
      end
      n_checks++;
      if (rsp_valid !== exp_valid) begin
        n_fail++; $display("FAIL rnd rsp_valid cyc %0d: got %b want %b", i, rsp_valid, exp_valid);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL rnd busy cyc %0d: got %b want %b", i, busy, exp_busy);
      end
      if (exp_valid) begin
        n_checks++;
        if (rsp_id !== 2'(exp_id) || rsp_p !== 15'(exp_p)) begin
          n_fail++;
          $display("FAIL rnd rsp cyc %0d: got id=%0d p=%0d want id=%0d p=%0d",
                   i, rsp_id, rsp_p, exp_id, exp_p);
        end
      end
      advance();
    end
  endtask

  initial begin
    ap_rst_n = 1'b0; arb_en = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_width_wrap();
    test_reset_mid_flight();
    test_arb_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
